// File: rtl/roce_rdma_write_segmenter.sv
// rtl/roce_rdma_write_segmenter.sv - splits one RDMA WRITE work request into per-packet RoCEv2 header descriptors
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_wr_*                   work request handshake (valid/ready) and fields
//   m_pkt_*                  per-packet descriptor handshake (valid/ready) and BTH/RETH fields
//   next_psn                 PSN following the last packet of the most recently completed WR
//   wr_done                  one-cycle pulse after the final descriptor handshake
//   busy                     a work request is being segmented

module roce_rdma_write_segmenter #(
    parameter int PMTU_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_wr_valid,
    output logic        s_wr_ready,
    input  logic [31:0] s_wr_dma_length,
    input  logic [63:0] s_wr_rem_addr,
    input  logic [31:0] s_wr_r_key,
    input  logic [23:0] s_wr_rem_qpn,
    input  logic [23:0] s_wr_start_psn,
    input  logic [31:0] s_wr_rem_ip_addr,

    output logic        m_pkt_valid,
    input  logic        m_pkt_ready,
    output logic [7:0]  m_pkt_opcode,
    output logic [23:0] m_pkt_psn,
    output logic [23:0] m_pkt_dest_qpn,
    output logic        m_pkt_reth_valid,
    output logic [63:0] m_pkt_reth_vaddr,
    output logic [31:0] m_pkt_reth_r_key,
    output logic [31:0] m_pkt_reth_dma_length,
    output logic [15:0] m_pkt_payload_length,
    output logic [31:0] m_pkt_ip_addr,
    output logic        m_pkt_last,

    output logic [23:0] next_psn,
    output logic        wr_done,
    output logic        busy
);

    localparam logic [31:0] PMTU = 32'd1 << PMTU_SHIFT;

    localparam logic [7:0] OP_FIRST  = 8'h06;
    localparam logic [7:0] OP_MIDDLE = 8'h07;
    localparam logic [7:0] OP_LAST   = 8'h08;
    localparam logic [7:0] OP_ONLY   = 8'h0A;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_next;
    logic [31:0] remaining;     // bytes not yet covered by descriptors already accepted

    logic        load;          // WR handshake this cycle
    logic        advance;       // non-final descriptor handshake
    logic        finish;        // final descriptor handshake
    logic [31:0] rem_n;
    logic [23:0] psn_n;
    logic        first_n;
    logic        is_last_n;
    logic [7:0]  opcode_n;

    // FSM next-state and handshake decode
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (s_wr_valid && s_wr_ready) begin
                    load       = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (m_pkt_ready) begin
                    if (m_pkt_last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fields of the descriptor that will be presented next. The current
    // PSN and first flag live directly in the output registers, so only
    // the remaining byte count needs separate state.
    always_comb begin
        rem_n   = remaining - PMTU;
        psn_n   = m_pkt_psn + 24'd1;
        first_n = 1'b0;
        if (load) begin
            rem_n   = s_wr_dma_length;
            psn_n   = s_wr_start_psn;
            first_n = 1'b1;
        end
        is_last_n = (rem_n <= PMTU);
        case ({first_n, is_last_n})
            2'b11:   opcode_n = OP_ONLY;
            2'b10:   opcode_n = OP_FIRST;
            2'b01:   opcode_n = OP_LAST;
            default: opcode_n = OP_MIDDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_wr_ready <= 1'b0;
        end else begin
            state      <= state_next;
            // Registered so it stays low during reset and rises one cycle after release.
            s_wr_ready <= (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining             <= '0;
            m_pkt_opcode          <= '0;
            m_pkt_psn             <= '0;
            m_pkt_dest_qpn        <= '0;
            m_pkt_reth_valid      <= 1'b0;
            m_pkt_reth_vaddr      <= '0;
            m_pkt_reth_r_key      <= '0;
            m_pkt_reth_dma_length <= '0;
            m_pkt_payload_length  <= '0;
            m_pkt_ip_addr         <= '0;
            m_pkt_last            <= 1'b0;
            next_psn              <= '0;
            wr_done               <= 1'b0;
        end else begin
            wr_done <= finish;
            if (finish) begin
                next_psn <= m_pkt_psn + 24'd1;
            end
            // Per-WR fields are captured once and held for every packet;
            // the RETH vaddr is deliberately not advanced per packet.
            if (load) begin
                m_pkt_dest_qpn        <= s_wr_rem_qpn;
                m_pkt_reth_vaddr      <= s_wr_rem_addr;
                m_pkt_reth_r_key      <= s_wr_r_key;
                m_pkt_reth_dma_length <= s_wr_dma_length;
                m_pkt_ip_addr         <= s_wr_rem_ip_addr;
            end
            if (load || advance) begin
                remaining            <= rem_n;
                m_pkt_psn            <= psn_n;
                m_pkt_reth_valid     <= first_n;
                m_pkt_opcode         <= opcode_n;
                m_pkt_last           <= is_last_n;
                m_pkt_payload_length <= is_last_n ? rem_n[15:0] : PMTU[15:0];
            end
        end
    end

    assign m_pkt_valid = (state == EMIT);
    assign busy        = (state == EMIT);

endmodule

// File: tb/tb_roce_rdma_write_segmenter.sv
// tb/tb_roce_rdma_write_segmenter.sv - directed self-checking bench for roce_rdma_write_segmenter

module tb_roce_rdma_write_segmenter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_wr_valid = 1'b0;
    logic        s_wr_ready;
    logic [31:0] s_wr_dma_length = '0;
    logic [63:0] s_wr_rem_addr = '0;
    logic [31:0] s_wr_r_key = '0;
    logic [23:0] s_wr_rem_qpn = '0;
    logic [23:0] s_wr_start_psn = '0;
    logic [31:0] s_wr_rem_ip_addr = '0;
    logic        m_pkt_valid;
    logic        m_pkt_ready = 1'b1;
    logic [7:0]  m_pkt_opcode;
    logic [23:0] m_pkt_psn;
    logic [23:0] m_pkt_dest_qpn;
    logic        m_pkt_reth_valid;
    logic [63:0] m_pkt_reth_vaddr;
    logic [31:0] m_pkt_reth_r_key;
    logic [31:0] m_pkt_reth_dma_length;
    logic [15:0] m_pkt_payload_length;
    logic [31:0] m_pkt_ip_addr;
    logic        m_pkt_last;
    logic [23:0] next_psn;
    logic        wr_done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    roce_rdma_write_segmenter #(.PMTU_SHIFT(10)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_wr_valid            (s_wr_valid),
        .s_wr_ready            (s_wr_ready),
        .s_wr_dma_length       (s_wr_dma_length),
        .s_wr_rem_addr         (s_wr_rem_addr),
        .s_wr_r_key            (s_wr_r_key),
        .s_wr_rem_qpn          (s_wr_rem_qpn),
        .s_wr_start_psn        (s_wr_start_psn),
        .s_wr_rem_ip_addr      (s_wr_rem_ip_addr),
        .m_pkt_valid           (m_pkt_valid),
        .m_pkt_ready           (m_pkt_ready),
        .m_pkt_opcode          (m_pkt_opcode),
        .m_pkt_psn             (m_pkt_psn),
        .m_pkt_dest_qpn        (m_pkt_dest_qpn),
        .m_pkt_reth_valid      (m_pkt_reth_valid),
        .m_pkt_reth_vaddr      (m_pkt_reth_vaddr),
        .m_pkt_reth_r_key      (m_pkt_reth_r_key),
        .m_pkt_reth_dma_length (m_pkt_reth_dma_length),
        .m_pkt_payload_length  (m_pkt_payload_length),
        .m_pkt_ip_addr         (m_pkt_ip_addr),
        .m_pkt_last            (m_pkt_last),
        .next_psn              (next_psn),
        .wr_done               (wr_done),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a WR from a negedge and returns at the negedge after its handshake.
    task automatic send_wr(input logic [31:0] len, input logic [23:0] psn, input logic hold_valid);
        int n;
        @(negedge clk);
        s_wr_valid       = 1'b1;
        s_wr_dma_length  = len;
        s_wr_start_psn   = psn;
        s_wr_rem_addr    = 64'h0000_1234_5678_9000 + 64'(len);
        s_wr_r_key       = 32'hCAFE_0000 | len;
        s_wr_rem_qpn     = 24'h00ABCD;
        s_wr_rem_ip_addr = 32'hC0A8_0102;
        n = 0;
        while (!s_wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk);
        if (!hold_valid) s_wr_valid = 1'b0;
    endtask

    // Checks the descriptor visible at this negedge; with m_pkt_ready high
    // it is consumed at the next posedge and we return at the following negedge.
    task automatic expect_pkt(input string tag, input logic [7:0] op, input logic [23:0] psn,
                              input logic [15:0] plen, input logic reth, input logic last,
                              input logic [31:0] dma_len);
        chk({tag, "_valid"}, 64'(m_pkt_valid), 64'd1);
        chk({tag, "_wr_ready_low"}, 64'(s_wr_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_opcode"}, 64'(m_pkt_opcode), 64'(op));
        chk({tag, "_psn"}, 64'(m_pkt_psn), 64'(psn));
        chk({tag, "_payload"}, 64'(m_pkt_payload_length), 64'(plen));
        chk({tag, "_reth_valid"}, 64'(m_pkt_reth_valid), 64'(reth));
        chk({tag, "_last"}, 64'(m_pkt_last), 64'(last));
        chk({tag, "_dma_len"}, 64'(m_pkt_reth_dma_length), 64'(dma_len));
        chk({tag, "_qpn"}, 64'(m_pkt_dest_qpn), 64'h00ABCD);
        chk({tag, "_ip"}, 64'(m_pkt_ip_addr), 64'hC0A8_0102);
        chk({tag, "_vaddr"}, m_pkt_reth_vaddr, 64'h0000_1234_5678_9000 + 64'(dma_len));
        @(negedge clk);
    endtask

    task automatic expect_done(input string tag, input logic [23:0] npsn);
        chk({tag, "_wr_done"}, 64'(wr_done), 64'd1);
        chk({tag, "_next_psn"}, 64'(next_psn), 64'(npsn));
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_valid"}, 64'(m_pkt_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(s_wr_ready), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(wr_done), 64'd0);
        chk({tag, "_next_psn_hold"}, 64'(next_psn), 64'(npsn));
    endtask

    logic [7:0]  snap_op;
    logic [23:0] snap_psn;
    logic [15:0] snap_len;
    logic        stalled;
    int          hs;

    initial begin
        // Reset state
        #12;
        chk("rst_wr_ready", 64'(s_wr_ready), 64'd0);
        chk("rst_valid", 64'(m_pkt_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_next_psn", 64'(next_psn), 64'd0);
        chk("rst_opcode", 64'(m_pkt_opcode), 64'd0);
        chk("rst_wr_done", 64'(wr_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", 64'(s_wr_ready), 64'd1);

        // Single-packet WR
        send_wr(32'd512, 24'h000010, 1'b0);
        expect_pkt("single", 8'h0A, 24'h000010, 16'd512, 1'b1, 1'b1, 32'd512);
        expect_done("single", 24'h000011);

        // Exact multiple of PMTU
        send_wr(32'd3072, 24'h000010, 1'b0);
        expect_pkt("mult0", 8'h06, 24'h000010, 16'd1024, 1'b1, 1'b0, 32'd3072);
        expect_pkt("mult1", 8'h07, 24'h000011, 16'd1024, 1'b0, 1'b0, 32'd3072);
        expect_pkt("mult2", 8'h08, 24'h000012, 16'd1024, 1'b0, 1'b1, 32'd3072);
        expect_done("mult", 24'h000013);

        // Remainder and PSN wrap
        send_wr(32'd2049, 24'hFFFFFE, 1'b0);
        expect_pkt("wrap0", 8'h06, 24'hFFFFFE, 16'd1024, 1'b1, 1'b0, 32'd2049);
        expect_pkt("wrap1", 8'h07, 24'hFFFFFF, 16'd1024, 1'b0, 1'b0, 32'd2049);
        expect_pkt("wrap2", 8'h08, 24'h000000, 16'd1, 1'b0, 1'b1, 32'd2049);
        expect_done("wrap", 24'h000001);

        // Zero length
        send_wr(32'd0, 24'h000100, 1'b0);
        expect_pkt("zero", 8'h0A, 24'h000100, 16'd0, 1'b1, 1'b1, 32'd0);
        expect_done("zero", 24'h000101);

        // Backpressure with a second WR queued behind the first
        send_wr(32'd4096, 24'h000020, 1'b1);
        s_wr_dma_length = 32'd0;
        s_wr_start_psn  = 24'h000050;
        s_wr_rem_addr   = 64'h0000_1234_5678_9000;
        s_wr_r_key      = 32'hCAFE_0000;
        hs = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 200 && hs < 4; cyc++) begin
            if (stalled) begin
                chk("bp_stall_opcode", 64'(m_pkt_opcode), 64'(snap_op));
                chk("bp_stall_psn", 64'(m_pkt_psn), 64'(snap_psn));
                chk("bp_stall_payload", 64'(m_pkt_payload_length), 64'(snap_len));
            end
            chk("bp_wr_ready_low", 64'(s_wr_ready), 64'd0);
            chk("bp_valid", 64'(m_pkt_valid), 64'd1);
            m_pkt_ready = ($urandom_range(0, 1) == 1) || (cyc % 5 == 4);
            if (m_pkt_ready) begin
                chk("bp_opcode", 64'(m_pkt_opcode),
                    64'((hs == 0) ? 8'h06 : (hs == 3) ? 8'h08 : 8'h07));
                chk("bp_psn", 64'(m_pkt_psn), 64'(24'h000020 + 24'(hs)));
                chk("bp_payload", 64'(m_pkt_payload_length), 64'd1024);
                chk("bp_reth_valid", 64'(m_pkt_reth_valid), 64'(hs == 0));
                chk("bp_last", 64'(m_pkt_last), 64'(hs == 3));
                chk("bp_dma_len", 64'(m_pkt_reth_dma_length), 64'd4096);
                hs++;
                stalled = 1'b0;
            end else begin
                snap_op  = m_pkt_opcode;
                snap_psn = m_pkt_psn;
                snap_len = m_pkt_payload_length;
                stalled  = 1'b1;
            end
            @(negedge clk);
        end
        m_pkt_ready = 1'b1;
        chk("bp_count", 64'(hs), 64'd4);
        chk("bp_wr_done", 64'(wr_done), 64'd1);
        chk("bp_next_psn", 64'(next_psn), 64'h000024);
        chk("bp_ready_after_done", 64'(s_wr_ready), 64'd1);
        @(negedge clk);
        s_wr_valid = 1'b0;
        expect_pkt("bp_second", 8'h0A, 24'h000050, 16'd0, 1'b1, 1'b1, 32'd0);
        expect_done("bp_second", 24'h000051);

        // Asynchronous reset in the middle of a 5-packet WR
        send_wr(32'd5000, 24'h000030, 1'b0);
        expect_pkt("ar0", 8'h06, 24'h000030, 16'd1024, 1'b1, 1'b0, 32'd5000);
        expect_pkt("ar1", 8'h07, 24'h000031, 16'd1024, 1'b0, 1'b0, 32'd5000);
        chk("ar_pre_valid", 64'(m_pkt_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid_drop", 64'(m_pkt_valid), 64'd0);
        chk("ar_busy_drop", 64'(busy), 64'd0);
        chk("ar_next_psn_clear", 64'(next_psn), 64'd0);
        chk("ar_wr_ready_low", 64'(s_wr_ready), 64'd0);
        @(negedge clk);
        chk("ar_no_done", 64'(wr_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_ready_after", 64'(s_wr_ready), 64'd1);
        chk("ar_no_done_after", 64'(wr_done), 64'd0);
        send_wr(32'd1500, 24'h000040, 1'b0);
        expect_pkt("ar_new0", 8'h06, 24'h000040, 16'd1024, 1'b1, 1'b0, 32'd1500);
        expect_pkt("ar_new1", 8'h08, 24'h000041, 16'd476, 1'b0, 1'b1, 32'd1500);
        expect_done("ar_new", 24'h000042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/roce_rdma_write_segmenter.md
# roce_rdma_write_segmenter

Consumes one RDMA WRITE work request (the QP and transfer metadata produced by the UDP connection manager once `metadata_valid`/`start_transfer` fire) and breaks it into a sequence of per-packet RoCEv2 header descriptors sized to the path MTU. Each descriptor carries the BTH opcode, PSN, destination QPN and payload length, plus RETH fields on the first packet. The downstream RoCE TX header/payload framer consumes these descriptors; this block touches no payload data.

## Interface
- `PMTU_SHIFT`, default 10: log2 of the path MTU in bytes; legal range 8..12, i.e. 256..4096 B.
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `s_wr_valid` in 1: work request valid.
- `s_wr_ready` out 1: work request ready.
- `s_wr_dma_length` in 32: transfer length in bytes.
- `s_wr_rem_addr` in 64: remote virtual address.
- `s_wr_r_key` in 32: remote key.
- `s_wr_rem_qpn` in 24: destination QPN.
- `s_wr_start_psn` in 24: PSN of the first packet.
- `s_wr_rem_ip_addr` in 32: destination IP address.
- `m_pkt_valid` out 1: descriptor valid.
- `m_pkt_ready` in 1: descriptor ready.
- `m_pkt_opcode` out 8: BTH opcode. 0x06 FIRST, 0x07 MIDDLE, 0x08 LAST, 0x0A ONLY.
- `m_pkt_psn` out 24: BTH PSN.
- `m_pkt_dest_qpn` out 24: BTH destination QP.
- `m_pkt_reth_valid` out 1: RETH present; high on FIRST and ONLY only.
- `m_pkt_reth_vaddr` out 64: RETH virtual address.
- `m_pkt_reth_r_key` out 32: RETH R_Key.
- `m_pkt_reth_dma_length` out 32: RETH DMA length (the full transfer length).
- `m_pkt_payload_length` out 16: payload bytes in this packet.
- `m_pkt_ip_addr` out 32: destination IP address.
- `m_pkt_last` out 1: high on the final descriptor of the work request.
- `next_psn` out 24: PSN following the last emitted packet.
- `wr_done` out 1: one-cycle pulse after the final descriptor handshake.
- `busy` out 1: high while a work request is in progress.

## Operation
- State machine has two states: IDLE and EMIT.
- IDLE behaviour:
  - `s_wr_ready`=1.
  - On `s_wr_valid && s_wr_ready`: latch all `s_wr_*` fields.
  - Set `remaining` = `s_wr_dma_length` (32-bit), `psn` = `s_wr_start_psn`, `first` = 1.
  - Go to EMIT.
- EMIT behaviour:
  - `m_pkt_valid`=1 and `s_wr_ready`=0.
  - Descriptor fields are registered and held stable while `m_pkt_valid && !m_pkt_ready`.
- Per-descriptor field rules (PMTU = 1<<PMTU_SHIFT):
  - `is_last` = (`remaining` <= PMTU).
  - `m_pkt_payload_length` = `is_last` ? `remaining[15:0]` : PMTU.
  - Opcode: `first && is_last` → ONLY; `first && !is_last` → FIRST; `!first && is_last` → LAST; otherwise MIDDLE.
  - `m_pkt_reth_valid` = `first`. The RETH fields always carry the latched WR values and are qualified by `m_pkt_reth_valid`. The vaddr is not advanced per packet.
  - `m_pkt_last` = `is_last`.
- On each EMIT handshake:
  - If `!is_last`: `remaining` -= PMTU, `psn` = (`psn`+1) mod 2^24, `first` = 0.
  - If `is_last`: `next_psn` = (`psn`+1) mod 2^24, pulse `wr_done`, go to IDLE.
- Zero-length WR: a single ONLY descriptor with `payload_length`=0 and RETH DMA length 0.
- Packet count is ceil(len/PMTU), minimum 1. The largest case is len=0xFFFFFFFF with PMTU 256, which gives 2^24 packets; the PSN wraps naturally.
- PSN arithmetic is strictly 24-bit modulo: 0xFFFFFF+1 = 0x000000.
- `busy` = (state == EMIT).
- `next_psn` holds its value until the next work request completes.

## Timing
- All outputs reset to 0 asynchronously:
  - State returns to IDLE.
  - `s_wr_ready`, `m_pkt_valid`, `wr_done`, `busy` = 0.
  - `next_psn` = 0.
  - All descriptor fields = 0.
- `s_wr_ready` rises in the first cycle after `rst` deasserts.
- WR handshake at cycle T → `m_pkt_valid`=1 with the first descriptor at T+1.
- With `m_pkt_ready` held high, an N-packet WR emits one descriptor per cycle, T+1..T+N.
- Final handshake at cycle L:
  - `wr_done`=1 and `next_psn` updated at L+1.
  - `busy`=0 and `s_wr_ready`=1 at L+1.
  - The next WR may be accepted at L+1, giving its first descriptor at L+2.
- `s_wr_ready` and `m_pkt_valid` are never high in the same cycle.
- Backpressure: `m_pkt_ready`=0 stalls EMIT indefinitely with all outputs frozen.
- `s_wr_valid` during EMIT is ignored. The upstream source holds it until `s_wr_ready`.
- `rst` mid-EMIT:
  - The in-flight WR is discarded.
  - `m_pkt_valid` drops immediately (async).
  - No `wr_done` pulse is generated.

## Test plan
- Single-packet WR: PMTU_SHIFT=10, len=512, start_psn=0x000010 → one ONLY (0x0A) descriptor with payload 512, reth_valid=1, psn 0x10, last=1; `next_psn`=0x11; `wr_done` pulse.
- Exact-multiple WR: len=3072, PMTU 1024 → FIRST/MIDDLE/LAST, each with payload 1024; PSNs 0x10, 0x11, 0x12; reth_valid only on the first descriptor; RETH DMA length 3072 on it.
- Remainder and PSN wrap: len=2049, start_psn=0xFFFFFE → FIRST psn 0xFFFFFE (1024), MIDDLE psn 0xFFFFFF (1024), LAST psn 0x000000 (payload 1); `next_psn`=0x000001.
- Zero length: len=0 → one ONLY descriptor with payload 0 and reth_dma_length 0; `wr_done` at the cycle after the handshake.
- Backpressure: len=4096, `m_pkt_ready` toggled randomly → exactly 4 descriptors; fields stable during stalls; `s_wr_ready`=0 throughout; the second queued WR is accepted only at the cycle after `wr_done`.
- Async reset: assert `rst` after 2 of 5 descriptors → `m_pkt_valid`, `busy`, `next_psn` = 0 immediately; no `wr_done`; after release `s_wr_ready`=1 and a new WR is processed correctly.
